pc_fetch_ctrl: RTL and testbench

- Sequencer for the 64-bit program-counter register and the instruction-fetch port of the pipelined RV64 core.
- Each cycle it chooses the next PC from these sources: reset vector, trap vector, branch/jump target, PC+4, or hold.
- It drives the PC register's write enable and next value, and runs the fetch request/ready handshake.
- It asserts IF/ID flush on redirects and handles redirects that arrive while a fetch is still outstanding.

---
 rtl/pc_ctrl_pkg.sv | 19 +
 rtl/pc_next_mux.sv | 44 ++++
 rtl/pc_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter fetch controller.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } pc_state_e;

  localparam logic [63:0] RESET_VECTOR_DEF = 64'h0000_0000_0000_0000;
  localparam logic [63:0] TRAP_VECTOR_DEF  = 64'h0000_0000_0000_0100;
  localparam logic [63:0] PC_INCR          = 64'd4;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC value plus the redirect-target alignment check.
module pc_next_mux
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF[XLEN-1:0],
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF[XLEN-1:0]
) (
  input  logic            sel_boot,
  input  logic            sel_trap,
  input  logic            sel_redir,
  input  logic            sel_pend,
  input  logic            sel_incr,
  input  logic [XLEN-1:0] pc_cur,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] pend_pc,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign
);

  // A misaligned redirect is turned into a trap; a trap always outranks it.
  always_comb begin
    misalign = 1'b0;
    if (sel_boot) begin
      pc_next = RESET_VECTOR;
    end else if (sel_trap) begin
      pc_next = TRAP_VECTOR;
    end else if (sel_redir) begin
      if (is_misaligned(redirect_target[1:0])) begin
        pc_next  = TRAP_VECTOR;
        misalign = 1'b1;
      end else begin
        pc_next = redirect_target;
      end
    end else if (sel_pend) begin
      pc_next = pend_pc;
    end else if (sel_incr) begin
      pc_next = pc_cur + XLEN'(PC_INCR);
    end else begin
      pc_next = pc_cur;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and instruction-fetch handshake controller; redirects that hit
// an unfinished fetch park their target in pend_q until the fetch drains.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF[XLEN-1:0],
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_write,
  output logic            imem_req,
  input  logic            imem_ready,
  output logic            fetch_valid,
  input  logic            hazard_stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume,
  output logic            if_flush,
  output logic            id_flush,
  output logic            halted,
  output logic            misalign_err
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pend_q;
  logic [XLEN-1:0] pc_next_s;
  logic            misalign_s;
  logic            sel_boot_s, sel_trap_s, sel_redir_s, sel_pend_s, sel_incr_s;
  logic            pend_load_s, pc_write_s, imem_req_s, fetch_valid_s, flush_s, halted_s;

  pc_next_mux #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RESET_VECTOR),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_mux (
    .sel_boot       (sel_boot_s),
    .sel_trap       (sel_trap_s),
    .sel_redir      (sel_redir_s),
    .sel_pend       (sel_pend_s),
    .sel_incr       (sel_incr_s),
    .pc_cur         (pc_cur),
    .redirect_target(redirect_target),
    .pend_pc        (pend_q),
    .pc_next        (pc_next_s),
    .misalign       (misalign_s)
  );

  // Next-state and control decode from the current state and event inputs.
  always_comb begin
    state_d       = state_q;
    sel_boot_s    = 1'b0;
    sel_trap_s    = 1'b0;
    sel_redir_s   = 1'b0;
    sel_pend_s    = 1'b0;
    sel_incr_s    = 1'b0;
    pend_load_s   = 1'b0;
    pc_write_s    = 1'b0;
    imem_req_s    = 1'b0;
    fetch_valid_s = 1'b0;
    flush_s       = 1'b0;
    halted_s      = 1'b0;
    case (state_q)
      BOOT: begin
        sel_boot_s = 1'b1;
        pc_write_s = 1'b1;
        state_d    = FETCH;
      end
      FETCH: begin
        imem_req_s = 1'b1;
        if (trap_req || redirect) begin
          sel_trap_s  = trap_req;
          sel_redir_s = redirect;
          flush_s     = 1'b1;
          if (imem_ready) begin
            pc_write_s = 1'b1;
          end else begin
            pend_load_s = 1'b1;
            state_d     = DRAIN;
          end
        end else if (halt_req) begin
          imem_req_s = 1'b0;
          state_d    = HALT;
        end else if (hazard_stall) begin
          pc_write_s = 1'b0;
        end else if (imem_ready) begin
          sel_incr_s    = 1'b1;
          pc_write_s    = 1'b1;
          fetch_valid_s = 1'b1;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      DRAIN: begin
        // Newer trap/redirect replaces the parked target; the in-flight word is dropped.
        imem_req_s  = 1'b1;
        sel_pend_s  = 1'b1;
        sel_trap_s  = trap_req;
        sel_redir_s = redirect;
        flush_s     = trap_req | redirect;
        pend_load_s = 1'b1;
        if (imem_ready) begin
          pc_write_s = 1'b1;
          state_d    = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      HALT: begin
        halted_s = 1'b1;
        if (trap_req) begin
          sel_trap_s = 1'b1;
          pc_write_s = 1'b1;
          flush_s    = 1'b1;
          state_d    = FETCH;
        end else if (resume) begin
          state_d = FETCH;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and parked redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pend_load_s) begin
        pend_q <= pc_next_s;
      end else begin
        pend_q <= pend_q;
      end
    end
  end

  assign pc_next      = rst_n ? pc_next_s : '0;
  assign pc_write     = rst_n & pc_write_s;
  assign imem_req     = rst_n & imem_req_s;
  assign fetch_valid  = rst_n & fetch_valid_s;
  assign if_flush     = rst_n & flush_s;
  assign id_flush     = rst_n & flush_s;
  assign halted       = rst_n & halted_s;
  assign misalign_err = rst_n & misalign_s;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the fetch/PC rules.
module tb_pc_fetch_ctrl;

  localparam logic [63:0] RST_VEC  = 64'h0;
  localparam logic [63:0] TRAP_VEC = 64'h100;
  localparam int M_BOOT = 0, M_RUN = 1, M_PEND = 2, M_HALT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc_cur, pc_next, redirect_target;
  logic        pc_write, imem_req, imem_ready, fetch_valid, hazard_stall;
  logic        redirect, trap_req, halt_req, resume;
  logic        if_flush, id_flush, halted, misalign_err;

  int total = 0;
  int bad = 0;

  int          mode, nmode;
  logic [63:0] pend, npend;
  logic [63:0] e_next;
  logic        e_wr, e_req, e_val, e_fl, e_halt, e_mis;
  logic [70:0] obs, expv;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next), .pc_write(pc_write),
    .imem_req(imem_req), .imem_ready(imem_ready), .fetch_valid(fetch_valid),
    .hazard_stall(hazard_stall), .redirect(redirect), .redirect_target(redirect_target),
    .trap_req(trap_req), .halt_req(halt_req), .resume(resume), .if_flush(if_flush),
    .id_flush(id_flush), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Reference rules: what the controller must do this cycle given mode and inputs.
  task automatic model_eval();
    logic        mis, ev;
    logic [63:0] dest;
    e_next = pc_cur; e_wr = 0; e_req = 0; e_val = 0; e_fl = 0; e_halt = 0; e_mis = 0;
    nmode = mode; npend = pend;
    mis  = redirect && (redirect_target % 64'd4 != 64'd0);
    ev   = trap_req || redirect;
    dest = trap_req ? TRAP_VEC : (redirect ? (mis ? TRAP_VEC : redirect_target) : pend);
    if (!rst_n) begin
      e_next = 64'h0; nmode = M_BOOT; npend = 64'h0;
    end else if (mode == M_BOOT) begin
      e_wr = 1; e_next = RST_VEC; nmode = M_RUN;
    end else if (mode == M_HALT) begin
      e_halt = 1;
      if (trap_req) begin
        e_wr = 1; e_next = TRAP_VEC; e_fl = 1; nmode = M_RUN;
      end else if (resume) nmode = M_RUN;
    end else begin
      e_req = 1;
      if (mode == M_PEND || ev) begin
        e_fl = ev; e_mis = mis && !trap_req;
        e_next = dest; npend = dest; e_wr = imem_ready;
        nmode = imem_ready ? M_RUN : M_PEND;
      end else if (halt_req) begin
        e_req = 0; nmode = M_HALT;
      end else if (!hazard_stall && imem_ready) begin
        e_wr = 1; e_val = 1; e_next = pc_cur + 64'd4;
      end
    end
    expv = {e_next, e_wr, e_req, e_val, e_fl, e_fl, e_halt, e_mis};
  endtask

  task automatic settle();
    #3;
    model_eval();
    obs = {pc_next, pc_write, imem_req, fetch_valid, if_flush, id_flush, halted, misalign_err};
  endtask

  // The PC register loads on the falling edge; the model advances on the rising edge.
  task automatic commit();
    @(negedge clk);
    if (pc_write) pc_cur = pc_next;
    @(posedge clk);
    mode = nmode; pend = npend;
    #1;
  endtask

  task automatic clear_in();
    imem_ready = 0; hazard_stall = 0; redirect = 0; redirect_target = 64'h0;
    trap_req = 0; halt_req = 0; resume = 0;
  endtask

  task automatic test_reset();
    logic [63:0] seq [4];
    seq[0] = 64'h0; seq[1] = 64'h4; seq[2] = 64'h8; seq[3] = 64'hC;
    rst_n = 0; imem_ready = 1; trap_req = 1;
    settle();
    total++;
    if (obs !== 71'h0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    commit();
    trap_req = 0; rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if (pc_next !== seq[i] || pc_write !== 1'b1 || fetch_valid !== (i != 0)) begin
        bad++; $display("FAIL boot_seq%0d pc_next=%h wr=%b fv=%b want=%h", i, pc_next, pc_write, fetch_valid, seq[i]);
      end
      commit();
    end
  endtask

  task automatic test_stall();
    clear_in(); pc_cur = 64'h10; imem_ready = 1; hazard_stall = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      total++;
      if (pc_write !== 1'b0 || fetch_valid !== 1'b0 || imem_req !== 1'b1 || obs !== expv) begin
        bad++; $display("FAIL stall%0d got=%h want=%h", i, obs, expv);
      end
      commit();
    end
    hazard_stall = 0;
    settle();
    total++;
    if (pc_next !== 64'h14 || pc_write !== 1'b1) begin bad++; $display("FAIL stall_release pc_next=%h want=14", pc_next); end
    commit();
  endtask

  task automatic test_redirect();
    clear_in(); pc_cur = 64'h20; imem_ready = 1; redirect = 1; redirect_target = 64'h200;
    settle();
    total++;
    if (pc_next !== 64'h200 || pc_write !== 1'b1 || if_flush !== 1'b1 || id_flush !== 1'b1 || fetch_valid !== 1'b0) begin
      bad++; $display("FAIL redirect got=%h want=%h", obs, expv);
    end
    commit();
    redirect = 0;
    settle();
    total++;
    if (pc_cur !== 64'h200 || pc_next !== 64'h204 || if_flush !== 1'b0 || fetch_valid !== 1'b1) begin
      bad++; $display("FAIL redirect_next pc_cur=%h pc_next=%h want=204", pc_cur, pc_next);
    end
    commit();
  endtask

  task automatic test_drain();
    clear_in(); pc_cur = 64'h80; redirect = 1; redirect_target = 64'h300;
    settle();
    total++;
    if (pc_write !== 1'b0 || if_flush !== 1'b1 || fetch_valid !== 1'b0) begin
      bad++; $display("FAIL drain_enter got=%h want=%h", obs, expv);
    end
    commit();
    redirect = 0; redirect_target = 64'h0;
    for (int i = 0; i < 3; i++) begin
      imem_ready = (i == 2); hazard_stall = (i == 2);
      settle();
      total++;
      if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || pc_write !== (i == 2) || if_flush !== 1'b0) begin
        bad++; $display("FAIL drain_wait%0d got=%h want=%h", i, obs, expv);
      end
      if (i == 2) begin
        total++;
        if (pc_next !== 64'h300) begin bad++; $display("FAIL drain_done pc_next=%h want=300", pc_next); end
      end
      commit();
    end
    hazard_stall = 0;
    settle();
    total++;
    if (pc_next !== 64'h304 || fetch_valid !== 1'b1) begin bad++; $display("FAIL drain_after pc_next=%h want=304", pc_next); end
    commit();
  endtask

  task automatic test_misalign();
    clear_in(); pc_cur = 64'h40; imem_ready = 1; redirect = 1; redirect_target = 64'h202;
    settle();
    total++;
    if (misalign_err !== 1'b1 || pc_next !== 64'h100 || pc_write !== 1'b1 || if_flush !== 1'b1 || id_flush !== 1'b1) begin
      bad++; $display("FAIL misalign got=%h want=%h", obs, expv);
    end
    commit();
    redirect = 0;
    settle();
    total++;
    if (misalign_err !== 1'b0 || if_flush !== 1'b0 || pc_next !== 64'h104) begin
      bad++; $display("FAIL misalign_pulse got=%h want=%h", obs, expv);
    end
    commit();
  endtask

  task automatic test_halt_reset_wrap();
    clear_in(); pc_cur = 64'h60; imem_ready = 1; halt_req = 1;
    settle();
    total++;
    if (imem_req !== 1'b0 || pc_write !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL halt_enter got=%h want=%h", obs, expv); end
    commit();
    halt_req = 0;
    for (int i = 0; i < 3; i++) begin
      resume = (i == 2);
      settle();
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || pc_write !== 1'b0) begin bad++; $display("FAIL halt_hold%0d got=%h want=%h", i, obs, expv); end
      commit();
    end
    resume = 0;
    settle();
    total++;
    if (halted !== 1'b0 || pc_cur !== 64'h60 || pc_next !== 64'h64) begin bad++; $display("FAIL resume pc_next=%h want=64", pc_next); end
    commit();
    imem_ready = 0; redirect = 1; redirect_target = 64'h500;
    settle(); commit();
    redirect = 0; rst_n = 0;
    settle();
    total++;
    if (obs !== 71'h0) begin bad++; $display("FAIL reset_in_drain got=%h want=0", obs); end
    commit();
    rst_n = 1; imem_ready = 1;
    settle();
    total++;
    if (pc_next !== 64'h0 || pc_write !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL reboot pc_next=%h wr=%b want=0/1", pc_next, pc_write); end
    commit();
    pc_cur = 64'hFFFF_FFFF_FFFF_FFFC;
    settle();
    total++;
    if (pc_next !== 64'h0 || pc_write !== 1'b1 || fetch_valid !== 1'b1) begin bad++; $display("FAIL wrap pc_next=%h want=0", pc_next); end
    commit();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      trap_req     = ($urandom_range(0, 15) == 0);
      redirect     = ($urandom_range(0, 7) == 0);
      redirect_target = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
      halt_req     = ($urandom_range(0, 19) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      hazard_stall = ($urandom_range(0, 3) == 0);
      imem_ready   = $urandom_range(0, 1) == 1;
      settle();
      total++;
      if (obs !== expv) begin bad++; $display("FAIL random%0d got=%h want=%h", i, obs, expv); end
      commit();
    end
  endtask

  initial begin
    clear_in(); rst_n = 0; pc_cur = 64'h0; mode = M_BOOT; pend = 64'h0;
    @(posedge clk); #1;
    test_reset();
    test_stall();
    test_redirect();
    test_drain();
    test_misalign();
    test_halt_reset_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
